// File: rtl/noc_traffic_source_pkg.sv
// noc_traffic_source_pkg: flit types, FSM states and LFSR helpers shared by NoC traffic blocks
package noc_traffic_source_pkg;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0);
  endfunction
endpackage

// File: rtl/noc_traffic_source_if.sv
// noc_traffic_source_if: valid/ready flit channel from a traffic source to a router local port
interface noc_traffic_source_if #(parameter int DATA_W = 16);
  logic valid;
  logic ready;
  logic [DATA_W+1:0] flit;
  modport master (output valid, flit, input ready);
  modport slave (input valid, flit, output ready);
endinterface

// File: rtl/noc_lfsr16.sv
// noc_lfsr16: free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up
module noc_lfsr16
  import noc_traffic_source_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  localparam logic [15:0] INIT = SEED == 16'h0 ? 16'h1 : SEED;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= INIT;
    else state <= lfsr_next(state);
endmodule

// File: rtl/noc_traffic_source.sv
// noc_traffic_source: random-rate fixed-length packet injector driving a router local port
module noc_traffic_source
  import noc_traffic_source_pkg::*;
#(
  parameter int          NODE_ID       = 0,
  parameter int          NUM_NODES     = 9,
  parameter int          DATA_W        = 16,
  parameter int          FLITS_PER_PKT = 4,
  parameter int          INJ_RATE      = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        send,
  noc_traffic_source_if.master        out,
  output logic [31:0]                 pkt_count,
  output logic                        busy
);
  localparam int DW = $clog2(NUM_NODES);
  localparam int IW = $clog2(FLITS_PER_PKT);
  localparam logic [7:0] SELF = 8'(NODE_ID);
  localparam logic [7:0] ALT = 8'((NODE_ID + 1) % NUM_NODES);
  localparam logic [IW-1:0] LAST = IW'(FLITS_PER_PKT - 2);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic valid_n;
  logic [DATA_W+1:0] flit_n;
  logic [31:0] count_n;
  logic [15:0] lfsr;
  logic [7:0] raw, dst;
  logic accept, inject;
  noc_lfsr16 #(.SEED(LFSR_SEED ^ 16'(NODE_ID))) u_lfsr (.clk, .reset, .state(lfsr));
  assign raw = 8'(lfsr[15:8] % NUM_NODES);
  assign dst = raw == SELF ? ALT : raw;
  assign accept = out.valid & out.ready;
  assign inject = send && ({1'b0, lfsr[7:0]} < 9'(INJ_RATE));
  assign busy = state != IDLE;
  // Outputs are computed one cycle ahead so flit and valid leave straight from flops
  always_comb begin
    state_n = state;
    idx_n = idx;
    valid_n = out.valid;
    flit_n = out.flit;
    count_n = pkt_count;
    unique case (state)
      IDLE: if (inject) begin
        state_n = HEAD;
        valid_n = 1'b1;
        flit_n = {FLIT_HEAD, DATA_W'(dst) | (DATA_W'(NODE_ID) << DW)};
      end
      HEAD, BODY: if (accept) begin
        idx_n = state == HEAD ? IW'(1) : idx + 1'b1;
        state_n = (state == HEAD ? FLITS_PER_PKT > 2 : idx != LAST) ? BODY : TAIL;
        flit_n = state_n == BODY ? {FLIT_BODY, DATA_W'(idx_n)} : {FLIT_TAIL, DATA_W'(pkt_count)};
      end
      TAIL: if (accept) begin
        state_n = IDLE;
        valid_n = 1'b0;
        flit_n = '0;
        count_n = pkt_count + 32'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      out.valid <= 1'b0;
      out.flit <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      out.valid <= valid_n;
      out.flit <= flit_n;
      pkt_count <= count_n;
    end
endmodule
